// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: ALU operation selects, opcode and funct
// constants, and the decoded bundle that travels from decode to execute.
package rv32_pkg;

    typedef enum logic [4:0] {
        ALU_ADD     = 5'd0,
        ALU_SUB     = 5'd1,
        ALU_AND     = 5'd2,
        ALU_OR      = 5'd3,
        ALU_XOR     = 5'd4,
        ALU_SLL     = 5'd5,
        ALU_SRL     = 5'd6,
        ALU_SRA     = 5'd7,
        ALU_ADDI    = 5'd8,
        ALU_ANDI    = 5'd9,
        ALU_ORI     = 5'd10,
        ALU_XORI    = 5'd11,
        ALU_SLLI    = 5'd12,
        ALU_SRLI    = 5'd13,
        ALU_SRAI    = 5'd14,
        ALU_SLT     = 5'd15,
        ALU_SLTU    = 5'd16,
        ALU_SLTI    = 5'd17,
        ALU_SLTIU   = 5'd18,
        ALU_LUI     = 5'd19,
        ALU_AUIPC   = 5'd20,
        ALU_ILLEGAL = 5'd31
    } alu_opsel_e;

    // Major opcodes handled by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_opsel_e  opsel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
        logic [31:0] pc;
    } decode_bundle_t;

endpackage

// File: rtl/rv32_instr_decoder.sv
// Pure combinational RV32I integer-ALU decoder: raw instruction word in,
// fully expanded execute bundle out. Illegal words get rd/imm/use_imm zeroed.
module rv32_instr_decoder
    import rv32_pkg::*;
(
    input  logic [31:0]    i_instr,
    input  logic [31:0]    i_pc,
    output decode_bundle_t o_bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_sh;
    logic [31:0] w_imm_u;

    alu_opsel_e  w_opsel;
    logic [31:0] w_imm;
    logic        w_use_imm;
    logic        w_illegal;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_sh = {27'b0, i_instr[24:20]};
    assign w_imm_u  = {i_instr[31:12], 12'b0};

    // Select the ALU operation and raw immediate; anything unmatched stays ILLEGAL
    always_comb begin
        w_opsel   = ALU_ILLEGAL;
        w_imm     = '0;
        w_use_imm = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        F3_ADD:  w_opsel = ALU_ADD;
                        F3_SLL:  w_opsel = ALU_SLL;
                        F3_SLT:  w_opsel = ALU_SLT;
                        F3_SLTU: w_opsel = ALU_SLTU;
                        F3_XOR:  w_opsel = ALU_XOR;
                        F3_SR:   w_opsel = ALU_SRL;
                        F3_OR:   w_opsel = ALU_OR;
                        F3_AND:  w_opsel = ALU_AND;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
                    w_opsel = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_SR) begin
                    w_opsel = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                w_use_imm = 1'b1;
                w_imm     = w_imm_i;
                case (w_funct3)
                    F3_ADD:  w_opsel = ALU_ADDI;
                    F3_SLT:  w_opsel = ALU_SLTI;
                    F3_SLTU: w_opsel = ALU_SLTIU;
                    F3_XOR:  w_opsel = ALU_XORI;
                    F3_OR:   w_opsel = ALU_ORI;
                    F3_AND:  w_opsel = ALU_ANDI;
                    F3_SLL: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == F7_BASE) begin
                            w_opsel = ALU_SLLI;
                        end
                    end
                    F3_SR: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == F7_BASE) begin
                            w_opsel = ALU_SRLI;
                        end else if (w_funct7 == F7_ALT) begin
                            w_opsel = ALU_SRAI;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                w_opsel   = ALU_LUI;
                w_imm     = w_imm_u;
                w_use_imm = 1'b1;
            end
            OPC_AUIPC: begin
                w_opsel   = ALU_AUIPC;
                w_imm     = w_imm_u;
                w_use_imm = 1'b1;
            end
            default: begin
                w_opsel = ALU_ILLEGAL;
            end
        endcase
    end

    assign w_illegal = (w_opsel == ALU_ILLEGAL);

    // Illegal instructions still flow downstream, but must not write a register
    assign o_bundle.opsel   = w_opsel;
    assign o_bundle.rs1     = i_instr[19:15];
    assign o_bundle.rs2     = i_instr[24:20];
    assign o_bundle.rd      = w_illegal ? 5'd0 : i_instr[11:7];
    assign o_bundle.imm     = w_illegal ? 32'd0 : w_imm;
    assign o_bundle.use_imm = w_use_imm & ~w_illegal;
    assign o_bundle.illegal = w_illegal;
    assign o_bundle.pc      = i_pc;

endmodule

// File: rtl/rv32_decode_stage.sv
// Decode pipeline stage: valid/ready handshake around rv32_instr_decoder,
// with either a one-entry skid buffer (registered if_ready) or a plain
// pipeline register (pass-through if_ready).
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter bit ENABLE_SKID = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_alu_opsel,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_imm,
    output logic        ex_use_imm,
    output logic [31:0] ex_pc,
    output logic        ex_illegal
);

    decode_bundle_t w_dec;
    decode_bundle_t r_out;
    logic           r_out_valid;
    logic           w_accept;
    logic           w_drain;

    rv32_instr_decoder u_decoder (
        .i_instr  (if_instr),
        .i_pc     (if_pc),
        .o_bundle (w_dec)
    );

    // Output register may take new data when empty or when its bundle leaves
    assign w_drain  = ~r_out_valid | ex_ready;
    assign w_accept = if_valid & if_ready;

    generate
        if (ENABLE_SKID) begin : g_skid
            decode_bundle_t r_skid;
            logic           r_skid_valid;
            logic           r_if_ready;
            logic           w_skid_next;

            assign if_ready = r_if_ready;

            // Skid occupancy after this edge (ignoring flush); if_ready tracks its inverse
            assign w_skid_next = w_drain ? (r_skid_valid & w_accept)
                                         : (r_skid_valid | w_accept);

            // Output register plus one skid entry; skid drains first to keep order
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out        <= '0;
                    r_out_valid  <= 1'b0;
                    r_skid       <= '0;
                    r_skid_valid <= 1'b0;
                    r_if_ready   <= 1'b0;
                end else if (flush) begin
                    r_out_valid  <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_if_ready   <= 1'b1;
                end else begin
                    if (w_drain) begin
                        if (r_skid_valid) begin
                            r_out        <= r_skid;
                            r_out_valid  <= 1'b1;
                            r_skid_valid <= w_accept;
                            if (w_accept) begin
                                r_skid <= w_dec;
                            end
                        end else begin
                            r_out_valid <= w_accept;
                            if (w_accept) begin
                                r_out <= w_dec;
                            end
                        end
                    end else if (w_accept) begin
                        r_skid       <= w_dec;
                        r_skid_valid <= 1'b1;
                    end
                    r_if_ready <= ~w_skid_next;
                end
            end
        end else begin : g_pipe
            logic r_live;

            // r_live holds if_ready low during reset and the cycle it releases
            assign if_ready = r_live & w_drain;

            // Single pipeline register, reloaded whenever it is empty or draining
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                    r_live      <= 1'b0;
                end else begin
                    r_live <= 1'b1;
                    if (flush) begin
                        r_out_valid <= 1'b0;
                    end else if (w_drain) begin
                        r_out_valid <= w_accept;
                        if (w_accept) begin
                            r_out <= w_dec;
                        end
                    end
                end
            end
        end
    endgenerate

    assign ex_valid     = r_out_valid;
    assign ex_alu_opsel = r_out.opsel;
    assign ex_rs1       = r_out.rs1;
    assign ex_rs2       = r_out.rs2;
    assign ex_rd        = r_out.rd;
    assign ex_imm       = r_out.imm;
    assign ex_use_imm   = r_out.use_imm;
    assign ex_pc        = r_out.pc;
    assign ex_illegal   = r_out.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: one skid instance and one plain-register
// instance share the same stimulus; each is tracked by a FIFO-occupancy
// model and a rule-based decode reference.
module tb_rv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        ex_ready = 1'b0;

    logic        s_if_ready, s_ex_valid, s_use_imm, s_illegal;
    logic [4:0]  s_opsel, s_rs1, s_rs2, s_rd;
    logic [31:0] s_imm, s_pc;
    logic        p_if_ready, p_ex_valid, p_use_imm, p_illegal;
    logic [4:0]  p_opsel, p_rs1, p_rs2, p_rd;
    logic [31:0] p_imm, p_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_decode_stage #(.ENABLE_SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(s_if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .ex_valid(s_ex_valid), .ex_ready(ex_ready),
        .ex_alu_opsel(s_opsel), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_imm(s_imm), .ex_use_imm(s_use_imm), .ex_pc(s_pc), .ex_illegal(s_illegal)
    );

    rv32_decode_stage #(.ENABLE_SKID(1'b0)) u_pipe (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(p_if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .ex_valid(p_ex_valid), .ex_ready(ex_ready),
        .ex_alu_opsel(p_opsel), .ex_rs1(p_rs1), .ex_rs2(p_rs2), .ex_rd(p_rd),
        .ex_imm(p_imm), .ex_use_imm(p_use_imm), .ex_pc(p_pc), .ex_illegal(p_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    typedef struct {
        int          opsel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } exp_t;

    // Reference decode written straight from the instruction-set rules
    function automatic exp_t ref_decode(logic [31:0] ins);
        exp_t e;
        int r0[8];
        int i0[8];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        r0 = '{0, 5, 15, 16, 4, 6, 3, 2};
        i0 = '{8, 12, 17, 18, 11, 13, 10, 9};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.opsel = 31;
        e.imm = 32'd0;
        e.use_imm = 1'b0;
        e.rd = 5'd0;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        if (op == 7'h33) begin
            if (f7 == 7'h00) e.opsel = r0[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.opsel = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.opsel = 7;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) e.opsel = 12;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) e.opsel = 13;
                else if (f7 == 7'h20) e.opsel = 14;
            end else begin
                e.opsel = i0[f3];
            end
            if (e.opsel != 31) begin
                e.use_imm = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'd0, ins[24:20]};
                else e.imm = {{20{ins[31]}}, ins[31:20]};
            end
        end else if (op == 7'h37 || op == 7'h17) begin
            e.opsel = (op == 7'h37) ? 19 : 20;
            e.use_imm = 1'b1;
            e.imm = {ins[31:12], 12'd0};
        end
        e.illegal = (e.opsel == 31);
        if (!e.illegal) e.rd = ins[11:7];
        return e;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: FIFO of accepted instructions ----------
    item_t q_s[$];
    item_t q_p[$];
    bit    m_live = 1'b0;
    bit    started = 1'b0;
    bit    m_acc_s, m_acc_p;

    // Skid stage behaves as a 2-deep queue, plain stage as 1-deep; flush/rst empty them
    always @(posedge clk) begin
        if (rst) begin
            q_s.delete();
            q_p.delete();
            m_live = 1'b0;
            started = 1'b1;
        end else begin
            m_acc_s = if_valid && m_live && (q_s.size() < 2);
            m_acc_p = if_valid && m_live && (q_p.size() == 0 || ex_ready);
            if (flush) begin
                q_s.delete();
                q_p.delete();
            end else begin
                if (ex_ready && q_s.size() > 0) void'(q_s.pop_front());
                if (ex_ready && q_p.size() > 0) void'(q_p.pop_front());
                if (m_acc_s) q_s.push_back('{instr: if_instr, pc: if_pc});
                if (m_acc_p) q_p.push_back('{instr: if_instr, pc: if_pc});
            end
            m_live = 1'b1;
        end
    end

    task automatic check_payload(string pre, logic [4:0] opsel, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [4:0] rd, logic [31:0] imm, logic use_imm, logic ill,
                                 logic [31:0] pc, item_t it);
        exp_t e;
        e = ref_decode(it.instr);
        cmp({pre, "_opsel"}, {27'd0, opsel}, e.opsel);
        cmp({pre, "_rd"}, {27'd0, rd}, {27'd0, e.rd});
        cmp({pre, "_imm"}, imm, e.imm);
        cmp({pre, "_use_imm"}, {31'd0, use_imm}, {31'd0, e.use_imm});
        cmp({pre, "_illegal"}, {31'd0, ill}, {31'd0, e.illegal});
        cmp({pre, "_pc"}, pc, it.pc);
        if (!e.illegal) begin
            cmp({pre, "_rs1"}, {27'd0, rs1}, {27'd0, e.rs1});
            cmp({pre, "_rs2"}, {27'd0, rs2}, {27'd0, e.rs2});
        end
    endtask

    // Compare both DUTs against the model on every falling edge
    always @(negedge clk) begin
        if (started) begin
            cmp("s_if_ready", {31'd0, s_if_ready}, {31'd0, m_live && q_s.size() < 2});
            cmp("s_ex_valid", {31'd0, s_ex_valid}, {31'd0, q_s.size() > 0});
            if (q_s.size() > 0)
                check_payload("s", s_opsel, s_rs1, s_rs2, s_rd, s_imm, s_use_imm, s_illegal, s_pc, q_s[0]);
            cmp("p_if_ready", {31'd0, p_if_ready},
                {31'd0, m_live && (q_p.size() == 0 || ex_ready)});
            cmp("p_ex_valid", {31'd0, p_ex_valid}, {31'd0, q_p.size() > 0});
            if (q_p.size() > 0)
                check_payload("p", p_opsel, p_rs1, p_rs2, p_rd, p_imm, p_use_imm, p_illegal, p_pc, q_p[0]);
        end
    end

    // ---------------- transfer log for the skid instance ----------------------
    int          cyc = 0;
    logic [31:0] xfer_pc[$];
    int          xfer_cyc[$];

    // One line per output transfer of the skid instance
    always @(posedge clk) begin
        cyc++;
        if (!rst && !flush && s_ex_valid && ex_ready) begin
            xfer_pc.push_back(s_pc);
            xfer_cyc.push_back(cyc);
            $display("XFER cyc=%0d pc=0x%08h opsel=%0d rd=%0d imm=0x%08h", cyc, s_pc, s_opsel, s_rd, s_imm);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(logic v, logic [31:0] ins, logic [31:0] pc, logic rdy, logic fl);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        ex_ready = rdy;
        flush    = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int s;
        int t;
        w = $urandom();
        s = $urandom_range(0, 5);
        t = $urandom_range(0, 3);
        case (s)
            0, 1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4:    w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
            default: ;
        endcase
        if (t < 2) w[31:25] = 7'h00;
        else if (t == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    int  k;
    bit  acc;
    int  n_before;

    initial begin
        // ---- reset state ----
        present(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        cmp("rst_s_valid", {31'd0, s_ex_valid}, 32'd0);
        cmp("rst_s_ready", {31'd0, s_if_ready}, 32'd0);
        cmp("rst_p_ready", {31'd0, p_if_ready}, 32'd0);
        cmp("rst_s_pc", s_pc, 32'd0);
        cmp("rst_s_imm", s_imm, 32'd0);
        rst = 1'b0;
        tick();
        cmp("post_rst_s_ready", {31'd0, s_if_ready}, 32'd1);
        cmp("post_rst_p_ready", {31'd0, p_if_ready}, 32'd1);

        // ---- and x3,x1,x2 ----
        present(1'b1, 32'h0020F1B3, 32'h100, 1'b1, 1'b0);
        tick();
        if_valid = 1'b0;
        cmp("and_valid", {31'd0, s_ex_valid}, 32'd1);
        cmp("and_opsel", {27'd0, s_opsel}, 32'd2);
        cmp("and_rs1", {27'd0, s_rs1}, 32'd1);
        cmp("and_rs2", {27'd0, s_rs2}, 32'd2);
        cmp("and_rd", {27'd0, s_rd}, 32'd3);
        cmp("and_use_imm", {31'd0, s_use_imm}, 32'd0);

        // ---- andi x5,x6,-1 ----
        present(1'b1, 32'hFFF37293, 32'h104, 1'b1, 1'b0);
        tick();
        if_valid = 1'b0;
        cmp("andi_opsel", {27'd0, s_opsel}, 32'd9);
        cmp("andi_rs1", {27'd0, s_rs1}, 32'd6);
        cmp("andi_rd", {27'd0, s_rd}, 32'd5);
        cmp("andi_imm", s_imm, 32'hFFFFFFFF);
        cmp("andi_use_imm", {31'd0, s_use_imm}, 32'd1);

        // ---- OP funct7=0100000 funct3=111 is illegal ----
        present(1'b1, 32'h4020F3B3, 32'h108, 1'b1, 1'b0);
        tick();
        if_valid = 1'b0;
        cmp("ill_opsel", {27'd0, s_opsel}, 32'd31);
        cmp("ill_flag", {31'd0, s_illegal}, 32'd1);
        cmp("ill_rd", {27'd0, s_rd}, 32'd0);
        cmp("ill_valid", {31'd0, s_ex_valid}, 32'd1);
        cmp("ill_pc", s_pc, 32'h108);
        cmp("ill_p_opsel", {27'd0, p_opsel}, 32'd31);
        tick();
        tick();

        // ---- skid: ex_ready low 3 cycles, four back-to-back instructions ----
        xfer_pc.delete();
        xfer_cyc.delete();
        k = 0;
        for (int c = 0; c < 40 && xfer_pc.size() < 4; c++) begin
            ex_ready = (c >= 3);
            if (k < 4) begin
                if_valid = 1'b1;
                if_pc    = 32'h200 + 32'(4 * k);
                if_instr = 32'h002081B3 + (32'(k) << 7);
            end else begin
                if_valid = 1'b0;
            end
            acc = s_if_ready && if_valid;
            tick();
            if (acc) k++;
            if (c == 2) begin
                cmp("skid_hold_pc", s_pc, 32'h200);
                cmp("skid_hold_valid", {31'd0, s_ex_valid}, 32'd1);
                cmp("skid_hold_ready", {31'd0, s_if_ready}, 32'd0);
            end
        end
        cmp("skid_count", xfer_pc.size(), 32'd4);
        for (int i = 0; i < xfer_pc.size() && i < 4; i++) begin
            cmp("skid_order", xfer_pc[i], 32'h200 + 32'(4 * i));
            cmp("skid_nogap", 32'(xfer_cyc[i] - xfer_cyc[0]), 32'(i));
        end
        present(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();

        // ---- flush with output and skid full plus a presented instruction ----
        present(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
        tick();
        present(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
        tick();
        n_before = xfer_pc.size();
        present(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b1);
        tick();
        present(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        cmp("flush_s_valid", {31'd0, s_ex_valid}, 32'd0);
        cmp("flush_s_ready", {31'd0, s_if_ready}, 32'd1);
        cmp("flush_p_valid", {31'd0, p_ex_valid}, 32'd0);
        ex_ready = 1'b1;
        tick();
        tick();
        tick();
        cmp("flush_nodeliver", xfer_pc.size(), 32'(n_before));

        // ---- reset while holding a stalled bundle ----
        present(1'b1, 32'hFFF37293, 32'h400, 1'b0, 1'b0);
        tick();
        if_valid = 1'b0;
        cmp("prerst_valid", {31'd0, s_ex_valid}, 32'd1);
        rst = 1'b1;
        tick();
        cmp("midrst_valid", {31'd0, s_ex_valid}, 32'd0);
        cmp("midrst_imm", s_imm, 32'd0);
        cmp("midrst_pc", s_pc, 32'd0);
        cmp("midrst_ready", {31'd0, s_if_ready}, 32'd0);
        rst = 1'b0;
        tick();
        cmp("relrst_ready", {31'd0, s_if_ready}, 32'd1);

        // ---- randomized traffic checked by the model every cycle ----
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            if_instr = rand_instr();
            if_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tick();
        end
        present(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
